// File: rtl/tdm_deframer.sv
// -----------------------------------------------------------------------------
// tdm_deframer
//
// Receive-side deframer for a four-channel time-multiplexed sample stream.
// A frame is four back-to-back segments (ch1..ch4) of LEN0..LEN3 samples.
// The block acquires alignment on a frame_start marker and then flywheels
// through up to MISS_MAX-1 missing markers. Each sample is routed to its
// channel's hold register, with a one-cycle valid strobe. The block also
// tracks, per channel, whether the last complete segment carried any nonzero
// sample.
//
// Ports
//   clk          system clock, all state changes on the rising edge
//   reset        synchronous active-high reset, overrides every other input
//   run          stream enable; when 1, data_in carries one sample per clk
//   data_in      multiplexed 8-bit sample
//   frame_start  marks data_in as segment 0, position 0
//   chN_data     last sample captured for channel N
//   ch_valid     bit k pulses for one cycle when ch(k+1)_data is updated
//   ch_active    bit k = last complete segment k held a nonzero sample
//   seg, count   position (segment, index) of the next expected sample
//   locked       frame alignment is held
//   sync_err     one-cycle pulse when frame_start arrives off-boundary
// -----------------------------------------------------------------------------
module tdm_deframer #(
    parameter int unsigned LEN0     = 121,
    parameter int unsigned LEN1     = 110,
    parameter int unsigned LEN2     = 77,
    parameter int unsigned LEN3     = 44,
    parameter int unsigned MISS_MAX = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [7:0] data_in,
    input  logic       frame_start,
    output logic [7:0] ch1_data,
    output logic [7:0] ch2_data,
    output logic [7:0] ch3_data,
    output logic [7:0] ch4_data,
    output logic [3:0] ch_valid,
    output logic [3:0] ch_active,
    output logic [1:0] seg,
    output logic [7:0] count,
    output logic       locked,
    output logic       sync_err
);

    // Miss counter only needs to reach MISS_MAX; it saturates there.
    localparam int unsigned   MW         = (MISS_MAX < 2) ? 1 : $clog2(MISS_MAX + 1);
    localparam logic [MW-1:0] MISS_LIMIT = MW'(MISS_MAX);

    // Index of the final sample in each segment (every LEN is at most 256).
    localparam logic [7:0] LAST0 = 8'(LEN0 - 1);
    localparam logic [7:0] LAST1 = 8'(LEN1 - 1);
    localparam logic [7:0] LAST2 = 8'(LEN2 - 1);
    localparam logic [7:0] LAST3 = 8'(LEN3 - 1);

    typedef enum logic [0:0] {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    // Last valid count value for a given segment.
    function automatic logic [7:0] seg_last(input logic [1:0] s);
        logic [7:0] r;
        case (s)
            2'd0:    r = LAST0;
            2'd1:    r = LAST1;
            2'd2:    r = LAST2;
            2'd3:    r = LAST3;
            default: r = LAST0;
        endcase
        return r;
    endfunction

    // ---------------------------------------------------------------------
    // State and registers
    // ---------------------------------------------------------------------
    state_e          state_q, state_d;
    logic [1:0]      seg_q, seg_d;
    logic [7:0]      count_q, count_d;
    logic [MW-1:0]   miss_q, miss_d;
    logic            nz_q, nz_d;
    logic [7:0]      ch_data_q [4];
    logic [7:0]      ch_data_d [4];
    logic [3:0]      ch_valid_q, ch_valid_d;
    logic [3:0]      ch_active_q, ch_active_d;
    logic            locked_q, locked_d;
    logic            sync_err_q, sync_err_d;

    // ---------------------------------------------------------------------
    // Shared decode of the current sample
    // ---------------------------------------------------------------------
    logic            nonzero_s;
    logic            at_boundary_s;
    logic [MW-1:0]   miss_inc_s;
    logic            flywheel_s;
    logic            lock_drop_s;
    logic            acquire_s;
    logic            realign_s;
    logic            capture_s;
    logic            cap_origin_s;
    logic [1:0]      cap_seg_s;
    logic [7:0]      cap_cnt_s;
    logic            last_s;
    logic            nz_base_s;

    assign nonzero_s     = (data_in != 8'd0);
    assign at_boundary_s = (seg_q == 2'd0) && (count_q == 8'd0);
    assign miss_inc_s    = (miss_q == MISS_LIMIT) ? miss_q : (miss_q + MW'(1));

    // Expected boundary reached with no marker: accept it anyway and count the miss.
    assign flywheel_s  = run && (state_q == ST_LOCKED) && at_boundary_s && !frame_start;
    assign lock_drop_s = flywheel_s && (miss_inc_s == MISS_LIMIT);

    assign acquire_s = run && (state_q == ST_HUNT) && frame_start;
    assign realign_s = run && (state_q == ST_LOCKED) && frame_start && !at_boundary_s;
    assign capture_s = run && ((state_q == ST_LOCKED) || frame_start);

    // A marker always forces the sample to (0,0), whatever was expected.
    assign cap_origin_s = acquire_s || realign_s;
    assign cap_seg_s    = cap_origin_s ? 2'd0 : seg_q;
    assign cap_cnt_s    = cap_origin_s ? 8'd0 : count_q;
    assign last_s       = (cap_cnt_s == seg_last(cap_seg_s));

    // A forced (0,0) starts a fresh segment, so an interrupted segment's
    // activity is dropped instead of being folded into ch_active.
    assign nz_base_s = cap_origin_s ? 1'b0 : nz_q;

    // ---------------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (!run) begin
            state_d = ST_HUNT;
        end else begin
            case (state_q)
                ST_HUNT: begin
                    if (frame_start) begin
                        state_d = ST_LOCKED;
                    end else begin
                        state_d = ST_HUNT;
                    end
                end
                ST_LOCKED: begin
                    if (lock_drop_s) begin
                        state_d = ST_HUNT;
                    end else begin
                        state_d = ST_LOCKED;
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    // Output and datapath next-values: capture, position advance, activity, misses.
    always_comb begin
        seg_d       = seg_q;
        count_d     = count_q;
        miss_d      = miss_q;
        nz_d        = nz_q;
        ch_data_d   = ch_data_q;
        ch_active_d = ch_active_q;
        ch_valid_d  = 4'b0000;
        sync_err_d  = 1'b0;
        locked_d    = (state_d == ST_LOCKED);

        if (!run) begin
            seg_d   = 2'd0;
            count_d = 8'd0;
            miss_d  = MW'(0);
            nz_d    = 1'b0;
        end else if (capture_s) begin
            ch_data_d[cap_seg_s]  = data_in;
            ch_valid_d[cap_seg_s] = 1'b1;
            sync_err_d            = realign_s;

            if (last_s) begin
                ch_active_d[cap_seg_s] = nz_base_s | nonzero_s;
                nz_d    = 1'b0;
                seg_d   = cap_seg_s + 2'd1;
                count_d = 8'd0;
            end else begin
                nz_d    = nz_base_s | nonzero_s;
                seg_d   = cap_seg_s;
                count_d = cap_cnt_s + 8'd1;
            end

            // Any marker (good boundary, acquire or realign) clears the misses.
            if (flywheel_s) begin
                miss_d = miss_inc_s;
            end else if (frame_start) begin
                miss_d = MW'(0);
            end else begin
                miss_d = miss_q;
            end

            // Lock lost: the flywheel sample is still delivered, but the
            // position is forgotten until the next marker.
            if (lock_drop_s) begin
                seg_d   = 2'd0;
                count_d = 8'd0;
                nz_d    = 1'b0;
                miss_d  = MW'(0);
            end else begin
                nz_d = nz_d;
            end
        end else begin
            // Hunting with no marker: the sample is ignored.
            seg_d = seg_q;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q       <= 2'd0;
            count_q     <= 8'd0;
            miss_q      <= MW'(0);
            nz_q        <= 1'b0;
            ch_data_q   <= '{default: 8'd0};
            ch_valid_q  <= 4'b0000;
            ch_active_q <= 4'b0000;
            locked_q    <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            seg_q       <= seg_d;
            count_q     <= count_d;
            miss_q      <= miss_d;
            nz_q        <= nz_d;
            ch_data_q   <= ch_data_d;
            ch_valid_q  <= ch_valid_d;
            ch_active_q <= ch_active_d;
            locked_q    <= locked_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign ch1_data  = ch_data_q[0];
    assign ch2_data  = ch_data_q[1];
    assign ch3_data  = ch_data_q[2];
    assign ch4_data  = ch_data_q[3];
    assign ch_valid  = ch_valid_q;
    assign ch_active = ch_active_q;
    assign seg       = seg_q;
    assign count     = count_q;
    assign locked    = locked_q;
    assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_tdm_deframer.sv
// -----------------------------------------------------------------------------
// tb_tdm_deframer
//
// Self-checking bench for tdm_deframer: a table of short directed vectors
// around acquisition, realign, run drop and reset, followed by hand-written
// multi-frame sequences for the strobe pattern, activity tracking, off-
// boundary markers, missing markers, a run drop and a reset mid-frame.
// Frame layout used by the bench: ch1 idx 0..120, ch2 121..230,
// ch3 231..307, ch4 308..351.
// -----------------------------------------------------------------------------
module tb_tdm_deframer;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic       frame_start;
    logic [7:0] data_in;
    logic [7:0] ch1_data, ch2_data, ch3_data, ch4_data;
    logic [3:0] ch_valid, ch_active;
    logic [1:0] seg;
    logic [7:0] count;
    logic       locked, sync_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tdm_deframer dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .data_in    (data_in),
        .frame_start(frame_start),
        .ch1_data   (ch1_data),
        .ch2_data   (ch2_data),
        .ch3_data   (ch3_data),
        .ch4_data   (ch4_data),
        .ch_valid   (ch_valid),
        .ch_active  (ch_active),
        .seg        (seg),
        .count      (count),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    typedef struct {
        logic       rst;
        logic       run;
        logic       fs;
        logic [7:0] din;
        logic [3:0] e_valid;
        logic [1:0] e_seg;
        logic [7:0] e_cnt;
        logic       e_lock;
        logic       e_serr;
        logic [7:0] e_ch1;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Apply inputs, advance one rising edge, then settle before sampling.
    task automatic drive(input logic r, input logic ru, input logic fs, input logic [7:0] d);
        reset       = r;
        run         = ru;
        frame_start = fs;
        data_in     = d;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] sample_val(input int idx, input bit zero3);
        if (zero3 && idx >= 231 && idx < 308) begin
            return 8'd0;
        end
        return 8'((idx % 255) + 1);
    endfunction

    function automatic logic [3:0] exp_strobe(input int idx);
        if (idx < 121) return 4'b0001;
        if (idx < 231) return 4'b0010;
        if (idx < 308) return 4'b0100;
        return 4'b1000;
    endfunction

    // Drive n frame samples starting at frame index start_idx.
    task automatic stream(input int start_idx, input int n, input bit zero3,
                          input bit mark, input bit chk_on);
        for (int k = 0; k < n; k++) begin
            int idx;
            idx = (start_idx + k) % 352;
            drive(1'b0, 1'b1, mark && (idx == 0), sample_val(idx, zero3));
            if (chk_on) begin
                chk($sformatf("strobe[%0d]", idx), 32'(ch_valid), 32'(exp_strobe(idx)));
            end
        end
    endtask

    initial begin
        reset       = 1'b1;
        run         = 1'b0;
        frame_start = 1'b0;
        data_in     = 8'd0;

        //          rst   run   fs    din     valid    seg   cnt   lock  serr  ch1
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 8'h55, 4'b0000, 2'd0, 8'd0, 1'b0, 1'b0, 8'h00};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 8'h07, 4'b0000, 2'd0, 8'd0, 1'b0, 1'b0, 8'h00};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 8'h09, 4'b0001, 2'd0, 8'd1, 1'b1, 1'b0, 8'h09};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 8'h0A, 4'b0001, 2'd0, 8'd2, 1'b1, 1'b0, 8'h0A};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 8'h0B, 4'b0001, 2'd0, 8'd1, 1'b1, 1'b1, 8'h0B};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'h0C, 4'b0001, 2'd0, 8'd2, 1'b1, 1'b0, 8'h0C};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 8'h0D, 4'b0000, 2'd0, 8'd0, 1'b0, 1'b0, 8'h0C};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 8'h0E, 4'b0000, 2'd0, 8'd0, 1'b0, 1'b0, 8'h0C};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 8'h00, 4'b0001, 2'd0, 8'd1, 1'b1, 1'b0, 8'h00};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 8'h05, 4'b0000, 2'd0, 8'd0, 1'b0, 1'b0, 8'h00};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 8'h06, 4'b0000, 2'd0, 8'd0, 1'b0, 1'b0, 8'h00};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 8'hFF, 4'b0001, 2'd0, 8'd1, 1'b1, 1'b0, 8'hFF};

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].rst, tbl[i].run, tbl[i].fs, tbl[i].din);
            chk($sformatf("v%0d.valid", i), 32'(ch_valid), 32'(tbl[i].e_valid));
            chk($sformatf("v%0d.seg", i),   32'(seg),      32'(tbl[i].e_seg));
            chk($sformatf("v%0d.count", i), 32'(count),    32'(tbl[i].e_cnt));
            chk($sformatf("v%0d.locked", i), 32'(locked),  32'(tbl[i].e_lock));
            chk($sformatf("v%0d.sync_err", i), 32'(sync_err), 32'(tbl[i].e_serr));
            chk($sformatf("v%0d.ch1", i),   32'(ch1_data), 32'(tbl[i].e_ch1));
            chk($sformatf("v%0d.active", i), 32'(ch_active), 32'(4'b0000));
        end

        // ---------------- A: one full frame, data 1..255 cycling ----------------
        drive(1'b1, 1'b0, 1'b0, 8'd0);
        stream(0, 121, 1'b0, 1'b1, 1'b1);
        chk("A.ch1_end", 32'(ch1_data), 32'(121));
        chk("A.seg1", 32'(seg), 32'(1));
        chk("A.cnt0", 32'(count), 32'(0));
        stream(121, 231, 1'b0, 1'b1, 1'b1);
        chk("A.locked", 32'(locked), 32'(1));
        chk("A.seg_wrap", 32'(seg), 32'(0));
        chk("A.cnt_wrap", 32'(count), 32'(0));
        chk("A.ch4", 32'(ch4_data), 32'(97));
        chk("A.active", 32'(ch_active), 32'(4'b1111));

        // ---------------- B: ch3 muted, then unmuted ----------------
        drive(1'b1, 1'b0, 1'b0, 8'd0);
        stream(0, 352, 1'b1, 1'b1, 1'b1);
        chk("B.active_muted", 32'(ch_active), 32'(4'b1011));
        stream(0, 307, 1'b0, 1'b1, 1'b1);
        chk("B.active_before", 32'(ch_active), 32'(4'b1011));
        stream(307, 1, 1'b0, 1'b1, 1'b1);
        chk("B.active_after", 32'(ch_active), 32'(4'b1111));
        stream(308, 44, 1'b0, 1'b1, 1'b1);

        // ---------------- C: marker at seg=1, count=50 ----------------
        stream(0, 171, 1'b0, 1'b1, 1'b1);
        chk("C.seg_pre", 32'(seg), 32'(1));
        chk("C.cnt_pre", 32'(count), 32'(50));
        drive(1'b0, 1'b1, 1'b1, 8'hA5);
        chk("C.sync_err", 32'(sync_err), 32'(1));
        chk("C.ch1", 32'(ch1_data), 32'(8'hA5));
        chk("C.valid", 32'(ch_valid), 32'(4'b0001));
        chk("C.seg", 32'(seg), 32'(0));
        chk("C.cnt", 32'(count), 32'(1));
        chk("C.active", 32'(ch_active), 32'(4'b1111));
        drive(1'b0, 1'b1, 1'b0, sample_val(1, 1'b0));
        chk("C.sync_err_off", 32'(sync_err), 32'(0));
        chk("C.cnt2", 32'(count), 32'(2));

        // ---------------- D: two missed markers ----------------
        stream(2, 350, 1'b0, 1'b0, 1'b1);
        chk("D.locked_pre", 32'(locked), 32'(1));
        stream(0, 1, 1'b0, 1'b0, 1'b1);
        chk("D.locked_miss1", 32'(locked), 32'(1));
        stream(1, 351, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 8'h5A);
        chk("D.locked_miss2", 32'(locked), 32'(0));
        chk("D.valid_miss2", 32'(ch_valid), 32'(4'b0001));
        chk("D.ch1_miss2", 32'(ch1_data), 32'(8'h5A));
        for (int i = 1; i <= 5; i++) begin
            drive(1'b0, 1'b1, 1'b0, sample_val(i, 1'b0));
            chk($sformatf("D.hunt_valid%0d", i), 32'(ch_valid), 32'(4'b0000));
            chk($sformatf("D.hunt_locked%0d", i), 32'(locked), 32'(0));
        end
        drive(1'b0, 1'b1, 1'b1, sample_val(0, 1'b0));
        chk("D.relock_valid", 32'(ch_valid), 32'(4'b0001));
        chk("D.relock_locked", 32'(locked), 32'(1));
        chk("D.relock_cnt", 32'(count), 32'(1));

        // ---------------- E: run dropped mid segment 2 ----------------
        stream(1, 240, 1'b0, 1'b0, 1'b1);
        chk("E.seg_pre", 32'(seg), 32'(2));
        chk("E.cnt_pre", 32'(count), 32'(10));
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b0, 8'h3C);
            chk($sformatf("E.valid%0d", i), 32'(ch_valid), 32'(4'b0000));
            chk($sformatf("E.locked%0d", i), 32'(locked), 32'(0));
            chk($sformatf("E.seg%0d", i), 32'(seg), 32'(0));
            chk($sformatf("E.cnt%0d", i), 32'(count), 32'(0));
        end
        chk("E.ch1", 32'(ch1_data), 32'(121));
        chk("E.ch2", 32'(ch2_data), 32'(231));
        chk("E.ch3", 32'(ch3_data), 32'(241));
        chk("E.ch4", 32'(ch4_data), 32'(97));
        chk("E.active", 32'(ch_active), 32'(4'b1111));
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, 8'h77);
            chk($sformatf("E.nofs_valid%0d", i), 32'(ch_valid), 32'(4'b0000));
            chk($sformatf("E.nofs_locked%0d", i), 32'(locked), 32'(0));
        end
        drive(1'b0, 1'b1, 1'b1, sample_val(0, 1'b0));
        chk("E.relock_valid", 32'(ch_valid), 32'(4'b0001));
        chk("E.relock_locked", 32'(locked), 32'(1));

        // ---------------- F: reset mid-frame with a marker ----------------
        stream(1, 5, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 8'h33);
        chk("F.ch1", 32'(ch1_data), 32'(0));
        chk("F.ch2", 32'(ch2_data), 32'(0));
        chk("F.ch3", 32'(ch3_data), 32'(0));
        chk("F.ch4", 32'(ch4_data), 32'(0));
        chk("F.valid", 32'(ch_valid), 32'(0));
        chk("F.active", 32'(ch_active), 32'(0));
        chk("F.seg", 32'(seg), 32'(0));
        chk("F.cnt", 32'(count), 32'(0));
        chk("F.locked", 32'(locked), 32'(0));
        chk("F.sync_err", 32'(sync_err), 32'(0));
        drive(1'b0, 1'b1, 1'b0, 8'h44);
        chk("F.hunt_locked", 32'(locked), 32'(0));
        chk("F.hunt_valid", 32'(ch_valid), 32'(0));
        chk("F.hunt_cnt", 32'(count), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tdm_deframer.md
Name: tdm_deframer

Overview:
- Receive-side counterpart of the four-channel time-multiplexed sample stream. Segment order is ch1..ch4, with segment lengths 121/110/77/44 samples, and a frame is 352 samples.
- Aligns to the frame using a frame_start marker and flywheels through missing markers.
- Routes each sample into a per-channel hold register with a one-cycle valid strobe.
- Reports per-channel activity (a segment that is all zero means the channel is muted at the source), lock status and sync errors.

Parameters:
- LEN0, 121, samples in segment 0 (ch1)
- LEN1, 110, samples in segment 1 (ch2)
- LEN2, 77, samples in segment 2 (ch3)
- LEN3, 44, samples in segment 3 (ch4)
- MISS_MAX, 2, consecutive frame boundaries without frame_start before lock is dropped

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- run  in  1  stream enable; 1 = data_in carries one sample per clk
- data_in  in  8  multiplexed sample
- frame_start  in  1  marks data_in as segment 0, position 0
- ch1_data, ch2_data, ch3_data, ch4_data  out  8 each  last sample captured for that channel
- ch_valid  out  4  one-cycle strobe; bit k = ch(k+1)_data updated this cycle
- ch_active  out  4  bit k = last complete segment k contained at least one nonzero sample
- seg  out  2  expected segment of the next sample
- count  out  8  expected position within seg of the next sample
- locked  out  1  frame alignment held
- sync_err  out  1  one-cycle pulse when frame_start arrives off-boundary

Behaviour:
- Reset (reset=1 at edge): state HUNT; all outputs are 0, including ch*_data, ch_active, seg, count, locked and sync_err; internal miss counter and nonzero accumulator are 0. Reset overrides all other inputs. Reset mid-frame discards alignment.
- run=0: state returns to HUNT; seg, count, locked and miss counter go to 0; nonzero accumulator is cleared. ch_valid and sync_err are 0. ch*_data and ch_active hold their values.
- HUNT (run=1):
  - frame_start=0: the sample is ignored and nothing changes.
  - frame_start=1: the sample is position (0,0). It is captured into ch1_data, ch_valid=0001 next cycle, {seg,count} becomes (0,1), state LOCKED, locked=1, miss counter 0.
- LOCKED (run=1), every cycle:
  - The sample at the expected position (seg,count) is written to ch(seg+1)_data.
  - ch_valid[seg] pulses on the following cycle (latency 1 cycle).
  - Position advances: count+1. When count=LENseg-1, count becomes 0 and seg becomes seg+1, wrapping 3 to 0.
- Marker check at LOCKED:
  - frame_start=1 and expected (0,0): good boundary, miss counter cleared.
  - frame_start=0 and expected (0,0): sample is still accepted as (0,0) (flywheel) and the miss counter increments.
    - If the incremented value equals MISS_MAX, the next state is HUNT and locked goes to 0 on that edge.
    - That sample is still captured and strobed.
  - frame_start=1 and expected not (0,0): sync_err pulses for 1 cycle; the sample is treated as (0,0) (realign).
    - It is captured into ch1_data.
    - Next position becomes (0,1); miss counter is cleared.
    - The accumulator for the interrupted segment is discarded and ch_active is not updated for it.
- Activity tracking:
  - nz accumulator = OR of (data_in != 0) over the current segment.
  - On the last sample of segment k (count=LENk-1), ch_active[k] <= nz | (data_in != 0) and the accumulator is cleared.
  - ch_active changes in the same cycle as that sample's ch_valid strobe.
- Outputs seg and count are registered and always show the position of the next expected sample.
- Widths:
  - count is 8 bits unsigned, and every LEN must be ≤ 256.
  - miss counter is wide enough for MISS_MAX and saturates, so it never wraps.

Test Plan:
- Reset, then run=1, frame_start on the first sample, data_in=1..255 cycling over 352 samples:
  - ch_valid strobes 0001 ×121, 0010 ×110, 0100 ×77, 1000 ×44.
  - ch1_data=121 after the ch1 run ends.
  - locked=1; after one frame, seg=0 and count=0.
- Same stream with every ch3 sample = 0 and the rest nonzero:
  - after the first frame, ch_active=1011.
  - make ch3 nonzero in the next frame: ch_active=1111 one cycle after its 77th sample.
- Locked, then frame_start asserted at seg=1, count=50:
  - sync_err=1 for exactly 1 cycle; ch1_data=that sample.
  - next cycle seg=0, count=1.
  - ch_active[1] unchanged.
- Locked, then frame_start withheld for 2 consecutive boundaries (MISS_MAX=2):
  - locked stays 1 after the first miss.
  - locked=0 on the cycle after the second boundary sample.
  - ch1 strobe still occurs for that sample; subsequent samples produce no strobes until frame_start.
- run dropped to 0 mid-segment 2 for 5 cycles, then raised with no frame_start:
  - ch_valid=0, locked=0, seg=0, count=0.
  - ch*_data unchanged; no strobes until frame_start=1.
- reset=1 asserted mid-frame together with frame_start=1:
  - the next cycle shows all outputs 0 and state HUNT; that marker is ignored.
